pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder_pkg.sv | 8 +
 rtl/adder_stage.sv | 12 +
 rtl/pipelined_adder.sv | 84 ++++++++
 tb/tb_pipelined_adder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: chunk width derivation and add/sub mode encoding shared by the adder pipeline
package pipelined_adder_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  function automatic int chunk_width(input int bit_width, input int stages);
    return bit_width / stages;
  endfunction
endpackage

// File: rtl/adder_stage.sv
// adder_stage: combinational W-bit ripple adder, ports a, b, cin in; sum, cout out
module adder_stage #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep chunked add/sub with operand skew, result de-skew and global-stall valid/ready flow
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int STAGES    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 cout,
  output logic                 overflow
);
  localparam int CHUNK = chunk_width(BIT_WIDTH, STAGES);
  localparam int L = STAGES - 1;
  localparam int M = BIT_WIDTH - 1;
  logic [STAGES-1:0]    v_r, c_r, v_nx, c_nx;
  logic [BIT_WIDTH-1:0] a_r [STAGES];
  logic [BIT_WIDTH-1:0] b_r [STAGES];
  logic [BIT_WIDTH-1:0] s_r [STAGES];
  logic [BIT_WIDTH-1:0] a_nx [STAGES];
  logic [BIT_WIDTH-1:0] b_nx [STAGES];
  logic [BIT_WIDTH-1:0] s_nx [STAGES];
  assign out_valid = v_r[L];
  assign in_ready  = out_ready || !out_valid;
  assign sum       = s_r[L];
  assign cout      = c_r[L];
  assign overflow  = (a_r[L][M] == b_r[L][M]) && (s_r[L][M] != a_r[L][M]);
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [BIT_WIDTH-1:0] ai, bi, si, sn;
    logic                 ci, vi;
    logic [CHUNK-1:0]     cs;
    if (k == 0) begin : g_head
      assign ai = a;
      assign bi = (sub == MODE_SUB) ? ~b : b;
      assign ci = (sub == MODE_SUB) ? ~cin : cin;
      assign si = '0;
      assign vi = in_valid;
    end else begin : g_body
      assign ai = a_r[k-1];
      assign bi = b_r[k-1];
      assign ci = c_r[k-1];
      assign si = s_r[k-1];
      assign vi = v_r[k-1];
    end
    adder_stage #(.W(CHUNK)) u_add (
      .a   (ai[k*CHUNK +: CHUNK]),
      .b   (bi[k*CHUNK +: CHUNK]),
      .cin (ci),
      .sum (cs),
      .cout(c_nx[k])
    );
    always_comb begin
      sn = si;
      sn[k*CHUNK +: CHUNK] = cs;
    end
    assign a_nx[k] = ai;
    assign b_nx[k] = bi;
    assign s_nx[k] = sn;
    assign v_nx[k] = vi;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_r <= '0;
      c_r <= '0;
      a_r <= '{default: '0};
      b_r <= '{default: '0};
      s_r <= '{default: '0};
    end else if (in_ready) begin
      v_r <= v_nx;
      c_r <= c_nx;
      a_r <= a_nx;
      b_r <= b_nx;
      s_r <= s_nx;
    end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed vectors, stall/reset/bubble sequences and random traffic against a queue-based arithmetic model
module tb_pipelined_adder;
  localparam int STAGES = 4;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow;
  logic [15:0] a, b, sum;
  int          checks = 0, errors = 0, stall_cnt = 0, pops = 0;
  logic [17:0] q[$];
  vec_t        tbl[7];
  pipelined_adder #(.BIT_WIDTH(16), .STAGES(STAGES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );
  always #5 clk = ~clk;
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb);
    int  u, s;
    logic co, ov;
    if (sb) begin
      u  = int'(x) - int'(y) - int'(ci);
      s  = int'($signed(x)) - int'($signed(y)) - int'(ci);
      co = u >= 0;
    end else begin
      u  = int'(x) + int'(y) + int'(ci);
      s  = int'($signed(x)) + int'($signed(y)) + int'(ci);
      co = u > 65535;
    end
    ov = s > 32767 || s < -32768;
    return {ov, co, u[15:0]};
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_vec(input vec_t v);
    in_valid  = 1'b1;
    a         = v.a;
    b         = v.b;
    cin       = v.cin;
    sub       = v.sub;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (STAGES - 2) begin
      step();
      chk("lat_early_valid", out_valid, 0);
    end
    step();
    chk("lat_valid", out_valid, 1);
    chk("vec_sum", sum, v.s);
    chk("vec_cout", cout, v.c);
    chk("vec_ovf", overflow, v.o);
    step();
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (!in_ready) stall_cnt++;
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_spurious: result %h emitted with nothing outstanding at %0t", sum, $time);
        end else begin
          chk("sb_result", {overflow, cout, sum}, q[0]);
          if (out_ready) begin
            void'(q.pop_front());
            pops++;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t nv;
    logic [17:0] e;
    bit   acc, fresh;
    int   i, cyc;
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{16'h0003, 16'h0004, 1'b1, 1'b0, 16'h0008, 1'b0, 1'b0};
    tbl[6] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 16'h1234;
    b         = 16'h5678;
    cin       = 1'b1;
    sub       = 1'b0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    foreach (tbl[t]) run_vec(tbl[t]);
    stall_cnt = 0;
    pops      = 0;
    i         = 0;
    cyc       = 0;
    fresh     = 1'b1;
    while (pops < 8 && cyc < 60) begin
      out_ready = !(cyc >= 6 && cyc < 9);
      if (i < 8) begin
        in_valid = 1'b1;
        if (fresh) begin
          a   = 16'($urandom);
          b   = 16'($urandom);
          cin = 1'($urandom_range(0, 1));
          sub = 1'($urandom_range(0, 1));
        end
      end else in_valid = 1'b0;
      #1;
      acc = in_valid && in_ready;
      step();
      if (acc) i++;
      fresh = acc;
      cyc++;
    end
    chk("stream_results", pops, 8);
    chk("stream_stall_cycles", stall_cnt, 3);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int t = 0; t < 3; t++) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0;
    step();
    chk("rst_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_sum", sum, 0);
    chk("async_rst_cout", cout, 0);
    chk("async_rst_ovf", overflow, 0);
    #2;
    rst_n = 1'b1;
    nv.a   = 16'hA5C3;
    nv.b   = 16'h3C5A;
    nv.cin = 1'b1;
    nv.sub = 1'b0;
    e      = model(nv.a, nv.b, nv.cin, nv.sub);
    {nv.o, nv.c, nv.s} = e;
    run_vec(nv);
    chk("rst_none_emerge", q.size(), 0);
    repeat (400) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (STAGES + 2) step();
    chk("random_drained", q.size(), 0);
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 8) && (c % 2 == 0);
      a        = 16'($urandom);
      b        = 16'($urandom);
      cin      = 1'($urandom_range(0, 1));
      sub      = 1'($urandom_range(0, 1));
      chk("alt_out_valid", out_valid, (c >= 4) && (c - 4 < 8) && ((c - 4) % 2 == 0));
      step();
    end
    chk("alt_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
